// File: rtl/match_ctrl.sv
// match_ctrl: match sequencer between the ball engine and the score display.
// Synchronises the start button, edge-detects goal levels, keeps both scores,
// gates ball motion (o_run / o_serve), times the post-goal pause in frames and
// declares the winner.
// Optional feature: define MATCH_CTRL_SERVE_ALT_EN to add o_serve_dir, which
// points the next serve toward the player who just conceded.
module match_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_animate,
  input  logic       i_start,
  input  logic       i_goal_p1,
  input  logic       i_goal_p2,
  output logic [3:0] o_score_p1,
  output logic [3:0] o_score_p2,
  output logic       o_run,
  output logic       o_serve,
  output logic [1:0] o_winner,
  output logic [1:0] o_state
`ifdef MATCH_CTRL_SERVE_ALT_EN
  ,
  output logic       o_serve_dir
`endif
);

  localparam logic [3:0] WIN_Q = WIN_SCORE[3:0];
  localparam logic [7:0] SF_Q  = SERVE_FRAMES[7:0];

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PLAY       = 2'b01,
    GOAL_PAUSE = 2'b10,
    GAME_OVER  = 2'b11
  } state_t;

  state_t     state;
  logic       start_s1;
  logic       start_s2;
  logic       start_s3;
  logic       start_ev;
  logic       g1_q;
  logic       g2_q;
  logic       ev1;
  logic       ev2;
  logic [7:0] pause_cnt;
  logic [3:0] p1_inc;
  logic [3:0] p2_inc;

  // The button is asynchronous: two flops for metastability, a third for the edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
    end else begin
      start_s1 <= i_start;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
    end
  end

  // Goal levels can stay high for many cycles; remember last value so each rise counts once.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      g1_q <= 1'b0;
      g2_q <= 1'b0;
    end else begin
      g1_q <= i_goal_p1;
      g2_q <= i_goal_p2;
    end
  end

  assign start_ev = start_s2 & ~start_s3;
  assign ev1      = i_goal_p1 & ~g1_q;
  assign ev2      = i_goal_p2 & ~g2_q;
  assign p1_inc   = o_score_p1 + 4'd1;
  assign p2_inc   = o_score_p2 + 4'd1;
  assign o_state  = state;

  // Match sequencer: state, scores, run/serve gating, pause counter and winner share one edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      o_score_p1 <= 4'd0;
      o_score_p2 <= 4'd0;
      o_run      <= 1'b0;
      o_serve    <= 1'b0;
      o_winner   <= 2'b00;
      pause_cnt  <= 8'd0;
    end else begin
      o_serve <= 1'b0;
      case (state)
        IDLE: begin
          o_run <= 1'b0;
          if (start_ev) begin
            state   <= PLAY;
            o_run   <= 1'b1;
            o_serve <= 1'b1;
          end
        end
        PLAY: begin
          o_run <= 1'b1;
          if (ev1 & ev2) begin
            state     <= GOAL_PAUSE;
            o_run     <= 1'b0;
            pause_cnt <= 8'd0;
          end else if (ev1) begin
            o_score_p1 <= p1_inc;
            o_run      <= 1'b0;
            if (p1_inc == WIN_Q) begin
              state    <= GAME_OVER;
              o_winner <= 2'b01;
            end else begin
              state     <= GOAL_PAUSE;
              pause_cnt <= 8'd0;
            end
          end else if (ev2) begin
            o_score_p2 <= p2_inc;
            o_run      <= 1'b0;
            if (p2_inc == WIN_Q) begin
              state    <= GAME_OVER;
              o_winner <= 2'b10;
            end else begin
              state     <= GOAL_PAUSE;
              pause_cnt <= 8'd0;
            end
          end
        end
        GOAL_PAUSE: begin
          o_run <= 1'b0;
          if (i_animate) begin
            pause_cnt <= pause_cnt + 8'd1;
            if (pause_cnt + 8'd1 == SF_Q) begin
              state   <= PLAY;
              o_run   <= 1'b1;
              o_serve <= 1'b1;
            end
          end
        end
        GAME_OVER: begin
          o_run <= 1'b0;
          if (start_ev) begin
            state      <= IDLE;
            o_score_p1 <= 4'd0;
            o_score_p2 <= 4'd0;
            o_winner   <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          o_run <= 1'b0;
        end
      endcase
    end
  end

`ifdef MATCH_CTRL_SERVE_ALT_EN
  // Next serve heads toward whoever just conceded; a let leaves it alone.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_serve_dir <= 1'b0;
    end else if (state == PLAY && (ev1 ^ ev2)) begin
      o_serve_dir <= ev1;
    end else if (state == GAME_OVER && start_ev) begin
      o_serve_dir <= 1'b0;
    end
  end
`endif

endmodule
